// File: rtl/sa_result_drain_if.sv
// Stream interface of the systolic-array result drain.
// Carries the feeder credit handshake, the raw bottom-row MAC lanes and the
// de-skewed output row stream. "slave" is the drain's view, "master" is the
// surrounding array/feeder/consumer view.
interface sa_result_drain_if #(
    parameter int N_COLS = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [16*N_COLS-1:0]  col_mac;
    logic                  out_valid;
    logic                  out_ready;
    logic [16*N_COLS-1:0]  out_row;
    logic                  overflow;

    modport master (
        output in_valid,
        output col_mac,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_row,
        input  overflow
    );

    modport slave (
        input  in_valid,
        input  col_mac,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_row,
        output overflow
    );
endinterface

// File: rtl/sa_result_drain.sv
// Systolic-array result drain.
// Tracks injected vectors through the array, samples each column of the bottom
// PE row at its skewed arrival time, re-aligns the lanes into one row, buffers
// rows in a small FIFO and issues input credits so the FIFO never overruns
// when the feeder honours in_ready.
// Optional feature: define SA_DRAIN_RELU_EN to clamp negative lanes (sign bit
// set, including -0) to 16'h0000 as rows are written into the FIFO.
module sa_result_drain #(
    parameter int N_ROWS     = 4,
    parameter int N_COLS     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    sa_result_drain_if.slave bus
);
    localparam int TRACK_LEN = N_ROWS + N_COLS;
    localparam int ROW_W     = 16 * N_COLS;
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int FLT_W     = $clog2(TRACK_LEN + 1);

    // ------------------------------------------------------------------
    // Vector tracking: bit j set means a vector was accepted j+1 edges ago.
    // The last bit marks the edge on which the aligned row is complete.
    // ------------------------------------------------------------------
    logic [TRACK_LEN-1:0] r_track;
    logic                 w_arrive;

    // Shift in_valid along the array latency plus the column skew.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_track <= '0;
        end else begin
            r_track <= {r_track[TRACK_LEN-2:0], bus.in_valid};
        end
    end

    assign w_arrive = r_track[TRACK_LEN-1];

    // ------------------------------------------------------------------
    // De-skew: lane c is captured once it leaves the array and then delayed
    // by N_COLS-1-c more stages, so all lanes line up on the arrival edge.
    // Lanes sample every cycle; only the tracked arrival edge matters.
    // ------------------------------------------------------------------
    logic [ROW_W-1:0] w_row;

    genvar gi;
    generate
        for (gi = 0; gi < N_COLS; gi++) begin : g_lane
            localparam int LEN = N_COLS - gi;
            logic [15:0] r_pipe [LEN];

            // Capture register followed by the lane's skew-compensating delay line.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int j = 0; j < LEN; j++) begin
                        r_pipe[j] <= '0;
                    end
                end else begin
                    r_pipe[0] <= bus.col_mac[16*gi +: 16];
                    for (int j = 1; j < LEN; j++) begin
                        r_pipe[j] <= r_pipe[j-1];
                    end
                end
            end

`ifdef SA_DRAIN_RELU_EN
            // Negative values, including -0, are clamped to +0 on the way in.
            assign w_row[16*gi +: 16] = r_pipe[LEN-1][15] ? 16'h0000 : r_pipe[LEN-1];
`else
            assign w_row[16*gi +: 16] = r_pipe[LEN-1];
`endif
        end
    endgenerate

    // ------------------------------------------------------------------
    // Aligned-row FIFO. A read that coincides with a write into a full
    // FIFO frees the slot, so the write is accepted without overflow.
    // ------------------------------------------------------------------
    logic [ROW_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [FLT_W-1:0] r_in_flight;
    logic             r_overflow;

    logic             w_full;
    logic             w_empty;
    logic             w_rd;
    logic             w_wr;
    logic             w_drop;
    logic [31:0]      w_occupancy;

    assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_rd    = !w_empty && bus.out_ready;
    assign w_wr    = w_arrive && (!w_full || w_rd);
    assign w_drop  = w_arrive && w_full && !w_rd;

    // Row storage; cleared on reset so out_row reads zero afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < FIFO_DEPTH; j++) begin
                r_mem[j] <= '0;
            end
        end else if (w_wr) begin
            r_mem[r_wr_ptr] <= w_row;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Vectors accepted but not yet arrived; a dropped arrival still retires.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_flight <= '0;
        end else begin
            case ({bus.in_valid, w_arrive})
                2'b10:   r_in_flight <= r_in_flight + FLT_W'(1);
                2'b01:   r_in_flight <= r_in_flight - FLT_W'(1);
                default: r_in_flight <= r_in_flight;
            endcase
        end
    end

    // Sticky flag for a row lost to a full FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    // Credit counts rows already buffered plus rows still inside the array.
    assign w_occupancy   = 32'(r_count) + 32'(r_in_flight);
    assign bus.in_ready  = (w_occupancy < 32'(FIFO_DEPTH));
    assign bus.out_valid = !w_empty;
    assign bus.out_row   = r_mem[r_rd_ptr];
    assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_sa_result_drain.sv
// Directed testbench for sa_result_drain (N_ROWS=4, N_COLS=4, FIFO_DEPTH=4).
// A small feeder model replays each injected vector onto col_mac with the
// array's column skew (lane c appears 4+c edges after injection, 16'hFFFF
// otherwise). Build with SA_DRAIN_RELU_EN defined to exercise the clamp.
module tb_sa_result_drain;
    localparam int NC = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sa_result_drain_if #(.N_COLS(NC)) bus ();

    sa_result_drain #(
        .N_ROWS(4),
        .N_COLS(NC),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // Feeder/array model: history of injected vectors, index j = injected j edges ago.
    logic [63:0] in_vec;
    logic [63:0] vp [7];
    logic        vv [7];

    always @(posedge clk) begin
        for (int j = 6; j > 0; j--) begin
            vp[j] = vp[j-1];
            vv[j] = vv[j-1];
        end
        vp[0] = in_vec;
        vv[0] = bus.in_valid;
    end

    always @(negedge clk) begin
        logic [63:0] m;
        m = '0;
        for (int c = 0; c < NC; c++) begin
            m[16*c +: 16] = vv[3+c] ? vp[3+c][16*c +: 16] : 16'hFFFF;
        end
        bus.col_mac = m;
    end

    function automatic logic [63:0] make_vec(input logic [15:0] base);
        return {base + 16'd3, base + 16'd2, base + 16'd1, base};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic inject(input logic [63:0] v);
        bus.in_valid = 1'b1;
        in_vec       = v;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", bus.overflow); end
        checks++; if (bus.out_row !== 64'h0) begin errors++; $display("FAIL reset_out_row got %h want 0", bus.out_row); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        inject(64'h3C03_3C02_3C01_3C00);
        repeat (7) tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_early got %b want 0", bus.out_valid); end
        tick();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", bus.out_valid); end
        checks++; if (bus.out_row !== 64'h3C03_3C02_3C01_3C00) begin errors++; $display("FAIL single_row got %h want 3c033c023c013c00", bus.out_row); end
        $display("single: row %h", bus.out_row);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_drained got %b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_credit_overflow();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            inject(make_vec(16'h1000 * 16'(i + 1)));
            checks++;
            if (bus.in_ready !== (i < 3)) begin errors++; $display("FAIL credit_in_ready_%0d got %b want %b", i, bus.in_ready, (i < 3)); end
        end
        inject(make_vec(16'h5000));
        repeat (7) tick();
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_before got %b want 0", bus.overflow); end
        tick();
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_after got %b want 1", bus.overflow); end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_row !== make_vec(16'h1000 * 16'(i + 1))) begin
                errors++; $display("FAIL ovf_row_%0d got %b/%h want 1/%h", i, bus.out_valid, bus.out_row, make_vec(16'h1000 * 16'(i + 1)));
            end
            $display("overflow drain: row %h", bus.out_row);
            tick();
        end
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got %b want 0", bus.out_valid); end
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", bus.overflow); end
        apply_reset();
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_cleared got %b want 0", bus.overflow); end
    endtask

    task automatic test_full_rw();
        for (int i = 0; i < 5; i++) begin
            inject(make_vec(16'h2000 + 16'h0100 * 16'(i)));
        end
        repeat (7) tick();
        checks++; if (bus.out_row !== make_vec(16'h2000)) begin errors++; $display("FAIL fullrw_head0 got %h want %h", bus.out_row, make_vec(16'h2000)); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL fullrw_overflow got %b want 0", bus.overflow); end
        checks++; if (bus.out_row !== make_vec(16'h2100)) begin errors++; $display("FAIL fullrw_head1 got %h want %h", bus.out_row, make_vec(16'h2100)); end
        bus.out_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_row !== make_vec(16'h2000 + 16'h0100 * 16'(i))) begin
                errors++; $display("FAIL fullrw_row_%0d got %b/%h want 1/%h", i, bus.out_valid, bus.out_row, make_vec(16'h2000 + 16'h0100 * 16'(i)));
            end
            $display("fullrw drain: row %h", bus.out_row);
            tick();
        end
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL fullrw_empty got %b want 0", bus.out_valid); end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            inject(make_vec(16'h6000 + 16'h0010 * 16'(i)));
        end
        repeat (8) tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_row !== make_vec(16'h6000)) begin
                errors++; $display("FAIL stall_hold_%0d got %b/%h want 1/%h", i, bus.out_valid, bus.out_row, make_vec(16'h6000));
            end
            tick();
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_row !== make_vec(16'h6000 + 16'h0010 * 16'(i))) begin
                errors++; $display("FAIL stall_drain_%0d got %b/%h want 1/%h", i, bus.out_valid, bus.out_row, make_vec(16'h6000 + 16'h0010 * 16'(i)));
            end
            $display("stall drain: row %h", bus.out_row);
            tick();
        end
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stall_empty got %b want 0", bus.out_valid); end
    endtask

    task automatic test_reset_midflight();
        inject(make_vec(16'h7000));
        repeat (8) tick();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL midrst_prefill got %b want 1", bus.out_valid); end
        inject(make_vec(16'h7100));
        repeat (2) tick();
        reset = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b want 1", bus.in_ready); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL midrst_overflow got %b want 0", bus.overflow); end
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_ghost_%0d got %b want 0", i, bus.out_valid); end
        end
    endtask

    task automatic test_relu();
        logic [63:0] expect_row;
`ifdef SA_DRAIN_RELU_EN
        expect_row = 64'h0000_0000_3C00_0000;
`else
        expect_row = 64'hC000_8000_3C00_0000;
`endif
        inject(64'hC000_8000_3C00_0000);
        repeat (8) tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_row !== expect_row) begin
            errors++; $display("FAIL relu_row got %b/%h want 1/%h", bus.out_valid, bus.out_row, expect_row);
        end
        $display("relu: row %h", bus.out_row);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.col_mac   = '1;
        in_vec        = '0;
        for (int j = 0; j < 7; j++) begin
            vv[j] = 1'b0;
            vp[j] = '0;
        end
        test_reset();
        test_single();
        test_credit_overflow();
        test_full_rw();
        test_stall();
        test_reset_midflight();
        test_relu();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
